// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg_scan_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned MAX_DIGITS = 32;

    typedef enum logic [0:0] {
        S_IDLE,
        S_SCAN
    } scan_state_t;

    // Callers truncate the result to their own digit count.
    function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
        return MAX_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/seg_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 and flags the last cycle; clear holds it at zero.
module seg_dwell_timer #(
    parameter int unsigned DWELL = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CBITS = $clog2(DWELL);

    logic [CBITS-1:0] cnt_q;

    assign tick = (cnt_q == CBITS'(DWELL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-aligned pattern updates.
// Define SEG_ACTIVE_LOW_EN to drive segment/digit_en inverted for common-anode displays.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned NDIGITS = 4,
    parameter int unsigned DWELL   = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     upd_valid,
    input  logic [SEG_W*NDIGITS-1:0] upd_data,
    output logic                     upd_ready,
    output logic [SEG_W-1:0]         segment,
    output logic [NDIGITS-1:0]       digit_en,
    output logic                     frame_start
);

    localparam int unsigned IBITS = $clog2(NDIGITS);

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic OUT_INV = 1'b1;
`else
    localparam logic OUT_INV = 1'b0;
`endif

    // Registers hold pin-level values, so blank also serves as the polarity mask.
    localparam logic [SEG_W-1:0]   SEG_BLANK = {SEG_W{OUT_INV}};
    localparam logic [NDIGITS-1:0] DIG_BLANK = {NDIGITS{OUT_INV}};

    scan_state_t              state_q, state_d;
    logic [IBITS-1:0]         idx_q, idx_d, idx_next;
    logic [SEG_W*NDIGITS-1:0] active_q, active_d;
    logic [SEG_W*NDIGITS-1:0] shadow_q, shadow_d;
    logic                     pending_q, pending_d;
    logic                     ready_q;
    logic [SEG_W-1:0]         segment_q, segment_d;
    logic [NDIGITS-1:0]       digit_en_q, digit_en_d;
    logic                     frame_start_q, frame_start_d;
    logic                     timer_clear;
    logic                     tick;
    logic                     accept;
    int unsigned              sel_base;

    seg_dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .tick  (tick)
    );

    assign accept   = upd_valid && !pending_q;
    assign idx_next = (idx_q == IBITS'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
    assign sel_base = SEG_W * 32'(idx_next);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        segment_d     = segment_q;
        digit_en_d    = digit_en_q;
        frame_start_d = 1'b0;
        timer_clear   = 1'b1;

        // Accept needs pending low and commit needs it high, so they never collide.
        if (accept) begin
            shadow_d  = upd_data;
            pending_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                segment_d  = SEG_BLANK;
                digit_en_d = DIG_BLANK;
                idx_d      = '0;
                if (pending_q) begin
                    active_d  = shadow_q;
                    pending_d = 1'b0;
                end
                if (enable) begin
                    state_d       = S_SCAN;
                    segment_d     = active_d[SEG_W-1:0] ^ SEG_BLANK;
                    digit_en_d    = NDIGITS'(onehot(0)) ^ DIG_BLANK;
                    frame_start_d = 1'b1;
                end
            end
            S_SCAN: begin
                if (!enable) begin
                    state_d    = S_IDLE;
                    segment_d  = SEG_BLANK;
                    digit_en_d = DIG_BLANK;
                    idx_d      = '0;
                end else begin
                    timer_clear = 1'b0;
                    if (tick) begin
                        idx_d = idx_next;
                        if (idx_next == '0) begin
                            frame_start_d = 1'b1;
                            if (pending_q) begin
                                active_d  = shadow_q;
                                pending_d = 1'b0;
                            end
                        end
                        segment_d  = active_d[sel_base +: SEG_W] ^ SEG_BLANK;
                        digit_en_d = NDIGITS'(onehot(32'(idx_next))) ^ DIG_BLANK;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            ready_q       <= 1'b1;
            segment_q     <= SEG_BLANK;
            digit_en_q    <= DIG_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            ready_q       <= !pending_d;
            segment_q     <= segment_d;
            digit_en_q    <= digit_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign upd_ready   = ready_q;
    assign segment     = segment_q;
    assign digit_en    = digit_en_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed vector bench for seg_scan_ctrl with NDIGITS=4, DWELL=4.
module tb_seg_scan_ctrl;

    localparam int unsigned NDIGITS = 4;
    localparam int unsigned DWELL   = 4;

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    localparam logic [27:0] P1 = {7'h06, 7'h5B, 7'h4F, 7'h66};
    localparam logic [27:0] P2 = {7'h7F, 7'h07, 7'h7D, 7'h6D};
    localparam logic [27:0] P3 = {7'h3F, 7'h39, 7'h71, 7'h77};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        upd_valid = 1'b0;
    logic [27:0] upd_data = '0;
    logic        upd_ready;
    logic [6:0]  segment;
    logic [3:0]  digit_en;
    logic        frame_start;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        r;
        logic        e;
        logic        v;
        logic [27:0] d;
        int          n;
        logic        rdy;
        logic [6:0]  seg;
        logic [3:0]  den;
        logic        fs;
    } vec_t;

    vec_t vecs[$];

    seg_scan_ctrl #(
        .NDIGITS (NDIGITS),
        .DWELL   (DWELL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .upd_valid   (upd_valid),
        .upd_data    (upd_data),
        .upd_ready   (upd_ready),
        .segment     (segment),
        .digit_en    (digit_en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic v, input logic [27:0] d,
                       input int n, input logic rdy, input logic [6:0] seg,
                       input logic [3:0] den, input logic fs);
        vec_t t;
        t.r = r; t.e = e; t.v = v; t.d = d; t.n = n;
        t.rdy = rdy; t.seg = seg; t.den = den; t.fs = fs;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic [27:0] d);
        rst = r; enable = e; upd_valid = v; upd_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic [6:0] seg,
                           input logic [3:0] den, input logic fs);
        chk({tag, ".upd_ready"}, 32'(upd_ready), 32'(rdy));
        chk({tag, ".segment"}, 32'(segment), 32'(seg ^ {7{INV}}));
        chk({tag, ".digit_en"}, 32'(digit_en), 32'(den ^ {4{INV}}));
        chk({tag, ".frame_start"}, 32'(frame_start), 32'(fs));
    endtask

    initial begin
        int found;

        // r  e  v  data n  rdy seg    den  fs
        add(1, 0, 0, 0,  2, 1, 7'h00, 4'h0, 0);   // reset
        add(0, 0, 0, 0,  1, 1, 7'h00, 4'h0, 0);
        add(0, 1, 0, 0,  1, 1, 7'h00, 4'h1, 1);   // blank scan
        add(0, 1, 0, 0,  3, 1, 7'h00, 4'h1, 0);
        add(0, 1, 0, 0,  4, 1, 7'h00, 4'h2, 0);
        add(0, 1, 0, 0,  4, 1, 7'h00, 4'h4, 0);
        add(0, 1, 0, 0,  4, 1, 7'h00, 4'h8, 0);
        add(0, 1, 0, 0,  1, 1, 7'h00, 4'h1, 1);
        add(0, 1, 0, 0,  3, 1, 7'h00, 4'h1, 0);
        add(0, 1, 0, 0,  1, 1, 7'h00, 4'h2, 0);
        add(0, 1, 1, P1, 1, 0, 7'h00, 4'h2, 0);   // accept P1
        add(0, 1, 1, P2, 2, 0, 7'h00, 4'h2, 0);   // P2 held while not ready
        add(0, 1, 1, P2, 4, 0, 7'h00, 4'h4, 0);
        add(0, 1, 1, P2, 4, 0, 7'h00, 4'h8, 0);
        add(0, 1, 1, P2, 1, 1, 7'h66, 4'h1, 1);   // P1 commits
        add(0, 1, 1, P2, 1, 0, 7'h66, 4'h1, 0);   // P2 accepted
        add(0, 1, 0, 0,  2, 0, 7'h66, 4'h1, 0);
        add(0, 1, 0, 0,  4, 0, 7'h4F, 4'h2, 0);
        add(0, 1, 0, 0,  4, 0, 7'h5B, 4'h4, 0);
        add(0, 1, 0, 0,  4, 0, 7'h06, 4'h8, 0);
        add(0, 1, 0, 0,  1, 1, 7'h6D, 4'h1, 1);   // P2 one frame later
        add(0, 1, 0, 0,  3, 1, 7'h6D, 4'h1, 0);
        add(0, 1, 0, 0,  1, 1, 7'h7D, 4'h2, 0);
        add(0, 0, 0, 0,  1, 1, 7'h00, 4'h0, 0);   // disable at frame cycle 6
        add(0, 0, 1, P3, 1, 0, 7'h00, 4'h0, 0);
        add(0, 0, 0, 0,  1, 1, 7'h00, 4'h0, 0);   // idle commit
        add(0, 0, 0, 0,  2, 1, 7'h00, 4'h0, 0);
        add(0, 1, 0, 0,  1, 1, 7'h77, 4'h1, 1);   // re-enable
        add(0, 1, 0, 0,  3, 1, 7'h77, 4'h1, 0);
        add(0, 1, 0, 0,  4, 1, 7'h71, 4'h2, 0);
        add(0, 1, 1, P1, 1, 0, 7'h39, 4'h4, 0);   // pending then reset
        add(1, 1, 0, 0,  1, 1, 7'h00, 4'h0, 0);
        add(0, 0, 0, 0,  2, 1, 7'h00, 4'h0, 0);
        add(0, 1, 0, 0,  1, 1, 7'h00, 4'h1, 1);
        add(0, 1, 0, 0,  3, 1, 7'h00, 4'h1, 0);
        add(0, 1, 0, 0,  4, 1, 7'h00, 4'h2, 0);
        add(0, 1, 0, 0,  4, 1, 7'h00, 4'h4, 0);
        add(0, 1, 0, 0,  4, 1, 7'h00, 4'h8, 0);
        add(0, 1, 1, P1, 1, 0, 7'h00, 4'h1, 1);   // accept on boundary tick
        add(0, 1, 0, 0,  3, 0, 7'h00, 4'h1, 0);
        add(0, 1, 0, 0,  4, 0, 7'h00, 4'h2, 0);
        add(0, 1, 0, 0,  4, 0, 7'h00, 4'h4, 0);
        add(0, 1, 0, 0,  4, 0, 7'h00, 4'h8, 0);
        add(0, 1, 0, 0,  1, 1, 7'h66, 4'h1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                drive(vecs[i].r, vecs[i].e, vecs[i].v, vecs[i].d);
                chk_out($sformatf("vec%0d.%0d", i, k), vecs[i].rdy, vecs[i].seg,
                        vecs[i].den, vecs[i].fs);
            end
        end

        // Accept in the same cycle as the idle-to-scan transition.
        drive(0, 0, 0, 0);
        chk_out("blank", 1'b1, 7'h00, 4'h0, 1'b0);
        drive(0, 0, 0, 0);
        drive(0, 1, 1, P2);
        chk_out("start_accept", 1'b0, 7'h66, 4'h1, 1'b1);
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            drive(0, 1, 0, 0);
            if (frame_start === 1'b1) begin
                found = i;
                break;
            end
        end
        chk("frame_period", 32'(found), 32'(NDIGITS * DWELL - 1 + 1));
        chk_out("start_commit", 1'b1, 7'h6D, 4'h1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
